// File: rtl/neuron_bus_arbiter.sv
// Clocked N-way arbiter for the shared neuron memory port: round-robin or
// channel-0-priority selection, burst ownership with a fairness cap.
module neuron_bus_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 4,
  parameter int EXT_PRIORITY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] read_address_in,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] write_address_in,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] write_data_in,
  input  logic [NUM_MASTERS-1:0]            write_enable_in,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              bus_busy,
  output logic [ADDR_WIDTH-1:0]             neuron_read_address,
  output logic [ADDR_WIDTH-1:0]             neuron_write_address,
  output logic [DATA_WIDTH-1:0]             neuron_write_data,
  output logic                              neuron_write_enable
);

  localparam int IDXW = (NUM_MASTERS < 2) ? 1 : $clog2(NUM_MASTERS);
  localparam int CNTW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        owner_q, owner_d;
  logic [IDXW-1:0]        last_q, last_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] others;
  logic [NUM_MASTERS-1:0] cand;
  logic                   cap_hit;
  logic                   keep;
  logic [IDXW-1:0]        win_idx;
  logic                   win_vld;
  logic [IDXW-1:0]        scan_idx;

  assign others  = req & ~(NUM_MASTERS'(1) << owner_q);
  assign cap_hit = (MAX_BURST != 0) && (cnt_q == CNTW'(MAX_BURST)) && (others != '0);
  assign keep    = (state_q == OWNED) && req[owner_q] && !cap_hit;
  // Any handover out of OWNED arbitrates without the current owner; this
  // covers both a dropped request and the fairness cap.
  assign cand    = (state_q == IDLE) ? req : others;

  always_comb begin
    win_idx  = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    if ((EXT_PRIORITY != 0) && cand[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
        scan_idx = IDXW'((int'(last_q) + i) % NUM_MASTERS);
        if (!win_vld && cand[scan_idx]) begin
          win_vld = 1'b1;
          win_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    if (keep) begin
      state_d = OWNED;
      cnt_d   = cnt_q;
      if ((MAX_BURST != 0) && (cnt_q != CNTW'(MAX_BURST)))
        cnt_d = cnt_q + CNTW'(1);
    end else if (win_vld) begin
      state_d = OWNED;
      owner_d = win_idx;
      last_d  = win_idx;
      cnt_d   = CNTW'(1);
    end
  end

  // Bus outputs load from the next owner so they always agree with grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      owner_q              <= '0;
      last_q               <= IDXW'(NUM_MASTERS - 1);
      cnt_q                <= '0;
      grant                <= '0;
      bus_busy             <= 1'b0;
      neuron_read_address  <= '0;
      neuron_write_address <= '0;
      neuron_write_data    <= '0;
      neuron_write_enable  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (state_d == OWNED) begin
        grant                <= NUM_MASTERS'(1) << owner_d;
        bus_busy             <= 1'b1;
        neuron_read_address  <= read_address_in[owner_d*ADDR_WIDTH +: ADDR_WIDTH];
        neuron_write_address <= write_address_in[owner_d*ADDR_WIDTH +: ADDR_WIDTH];
        neuron_write_data    <= write_data_in[owner_d*DATA_WIDTH +: DATA_WIDTH];
        neuron_write_enable  <= write_enable_in[owner_d] & req[owner_d];
      end else begin
        grant                <= '0;
        bus_busy             <= 1'b0;
        neuron_read_address  <= '0;
        neuron_write_address <= '0;
        neuron_write_data    <= '0;
        neuron_write_enable  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_bus_arbiter.sv
// Self-checking bench for neuron_bus_arbiter: three configurations driven from
// a vector table, expectations queued at drive time and checked after the edge.
module tb_neuron_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // A: 2 masters, ext priority, burst cap 4
  logic [1:0]  a_req, a_we, a_grant;
  logic [15:0] a_ra, a_wa, a_wd;
  logic        a_busy, a_nwe;
  logic [7:0]  a_nra, a_nwa, a_nwd;
  // B: 4 masters, pure round-robin, burst cap 1
  logic [3:0]  b_req, b_we, b_grant;
  logic [31:0] b_ra, b_wa, b_wd;
  logic        b_busy, b_nwe;
  logic [7:0]  b_nra, b_nwa, b_nwd;
  // C: 2 masters, ext priority, unlimited burst
  logic [1:0]  c_req, c_we, c_grant;
  logic [15:0] c_ra, c_wa, c_wd;
  logic        c_busy, c_nwe;
  logic [7:0]  c_nra, c_nwa, c_nwd;

  neuron_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(8),
                       .MAX_BURST(4), .EXT_PRIORITY(1)) u_a (
    .clk(clk), .reset(reset), .req(a_req), .read_address_in(a_ra),
    .write_address_in(a_wa), .write_data_in(a_wd), .write_enable_in(a_we),
    .grant(a_grant), .bus_busy(a_busy), .neuron_read_address(a_nra),
    .neuron_write_address(a_nwa), .neuron_write_data(a_nwd),
    .neuron_write_enable(a_nwe));

  neuron_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8),
                       .MAX_BURST(1), .EXT_PRIORITY(0)) u_b (
    .clk(clk), .reset(reset), .req(b_req), .read_address_in(b_ra),
    .write_address_in(b_wa), .write_data_in(b_wd), .write_enable_in(b_we),
    .grant(b_grant), .bus_busy(b_busy), .neuron_read_address(b_nra),
    .neuron_write_address(b_nwa), .neuron_write_data(b_nwd),
    .neuron_write_enable(b_nwe));

  neuron_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(8),
                       .MAX_BURST(0), .EXT_PRIORITY(1)) u_c (
    .clk(clk), .reset(reset), .req(c_req), .read_address_in(c_ra),
    .write_address_in(c_wa), .write_data_in(c_wd), .write_enable_in(c_we),
    .grant(c_grant), .bus_busy(c_busy), .neuron_read_address(c_nra),
    .neuron_write_address(c_nwa), .neuron_write_data(c_nwd),
    .neuron_write_enable(c_nwe));

  typedef struct {
    bit               rst;
    int               dut;
    logic [3:0]       req;
    logic [3:0]       we;
    logic [3:0][7:0]  val;
    logic [3:0]       exp_grant;
    string            name;
  } vec_t;

  typedef struct {
    int          dut;
    logic [3:0]  grant;
    logic        busy;
    logic [31:0] bus;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [3:0][7:0] VA  = {8'h00, 8'h00, 8'hEF, 8'hBE};
  localparam logic [3:0][7:0] VA2 = {8'h00, 8'h00, 8'h33, 8'hBE};
  localparam logic [3:0][7:0] VB  = {8'h44, 8'h33, 8'h22, 8'h11};

  function automatic vec_t mk(bit rst, int dut, logic [3:0] rq, logic [3:0] we,
                              logic [3:0][7:0] val, logic [3:0] g, string n);
    vec_t v;
    v.rst = rst; v.dut = dut; v.req = rq; v.we = we;
    v.val = val; v.exp_grant = g; v.name = n;
    return v;
  endfunction

  // Channel i presents read=val, write addr=val^55, data=~val.
  function automatic exp_t expect_of(vec_t v);
    exp_t e;
    e.dut = v.dut; e.grant = v.exp_grant; e.busy = 1'b0; e.bus = '0; e.name = v.name;
    for (int i = 0; i < 4; i++) begin
      if (v.exp_grant[i]) begin
        e.busy = 1'b1;
        e.bus  = {v.val[i], v.val[i] ^ 8'h55, ~v.val[i], 7'b0, v.we[i] & v.req[i]};
      end
    end
    return e;
  endfunction

  task automatic clear_inputs();
    a_req = '0; a_we = '0; a_ra = '0; a_wa = '0; a_wd = '0;
    b_req = '0; b_we = '0; b_ra = '0; b_wa = '0; b_wd = '0;
    c_req = '0; c_we = '0; c_ra = '0; c_wa = '0; c_wd = '0;
  endtask

  task automatic drive(input vec_t v);
    case (v.dut)
      0: begin
        a_req = v.req[1:0]; a_we = v.we[1:0];
        for (int i = 0; i < 2; i++) begin
          a_ra[i*8 +: 8] = v.val[i]; a_wa[i*8 +: 8] = v.val[i] ^ 8'h55; a_wd[i*8 +: 8] = ~v.val[i];
        end
      end
      1: begin
        b_req = v.req; b_we = v.we;
        for (int i = 0; i < 4; i++) begin
          b_ra[i*8 +: 8] = v.val[i]; b_wa[i*8 +: 8] = v.val[i] ^ 8'h55; b_wd[i*8 +: 8] = ~v.val[i];
        end
      end
      default: begin
        c_req = v.req[1:0]; c_we = v.we[1:0];
        for (int i = 0; i < 2; i++) begin
          c_ra[i*8 +: 8] = v.val[i]; c_wa[i*8 +: 8] = v.val[i] ^ 8'h55; c_wd[i*8 +: 8] = ~v.val[i];
        end
      end
    endcase
  endtask

  task automatic read_act(input int dut, output logic [3:0] g, output logic busy,
                          output logic [31:0] bus);
    case (dut)
      0:       begin g = {2'b00, a_grant}; busy = a_busy; bus = {a_nra, a_nwa, a_nwd, 7'b0, a_nwe}; end
      1:       begin g = b_grant;          busy = b_busy; bus = {b_nra, b_nwa, b_nwd, 7'b0, b_nwe}; end
      default: begin g = {2'b00, c_grant}; busy = c_busy; bus = {c_nra, c_nwa, c_nwd, 7'b0, c_nwe}; end
    endcase
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int dut, input string name);
    logic [3:0] g; logic busy; logic [31:0] bus;
    read_act(dut, g, busy, bus);
    cmp({name, "_grant"}, 64'(g), 64'd0);
    cmp({name, "_busy"},  64'(busy), 64'd0);
    cmp({name, "_bus"},   64'(bus), 64'd0);
  endtask

  task automatic check_out();
    exp_t e; logic [3:0] g; logic busy; logic [31:0] bus;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      read_act(e.dut, g, busy, bus);
      cmp({e.name, "_grant"}, 64'(g), 64'(e.grant));
      cmp({e.name, "_busy"},  64'(busy), 64'(e.busy));
      cmp({e.name, "_bus"},   64'(bus), 64'(e.bus));
      cmp({e.name, "_onehot"}, 64'($onehot0(g)), 64'd1);
    end
  endtask

  task automatic do_reset(input int dut);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero(dut, "rst_state");
  endtask

  task automatic apply_now(input vec_t v);
    drive(v);
    sb.push_back(expect_of(v));
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic apply(input vec_t v);
    if (v.rst) do_reset(v.dut);
    @(negedge clk);
    apply_now(v);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();

    // A: ext priority win, 4-cycle cap, handback, data follows, release
    vecs.push_back(mk(1, 0, 4'b0011, 4'b0001, VA,  4'b0001, "a_ext0"));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 4'b0011, 4'b0001, VA, 4'b0001, "a_burst0"));
    vecs.push_back(mk(0, 0, 4'b0011, 4'b0001, VA,  4'b0010, "a_cap"));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 4'b0011, 4'b0001, VA, 4'b0010, "a_burst1"));
    vecs.push_back(mk(0, 0, 4'b0011, 4'b0001, VA,  4'b0001, "a_cap_back"));
    vecs.push_back(mk(0, 0, 4'b0010, 4'b0001, VA,  4'b0010, "a_drop0"));
    vecs.push_back(mk(0, 0, 4'b0010, 4'b0011, VA2, 4'b0010, "a_follow"));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0011, VA,  4'b0000, "a_idle"));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0011, VA,  4'b0000, "a_we_noreq"));
    vecs.push_back(mk(1, 0, 4'b0010, 4'b0010, VA,  4'b0010, "a_ch1_only"));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0010, VA,  4'b0000, "a_release"));
    // B: strict rotation, then simultaneous drop/raise handover
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1010, VB, 4'b0001, "b_rr0"));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b1010, VB, 4'b0010, "b_rr1"));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b1010, VB, 4'b0100, "b_rr2"));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b1010, VB, 4'b1000, "b_rr3"));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b1010, VB, 4'b0001, "b_rr4"));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b1010, VB, 4'b0010, "b_own1"));
    vecs.push_back(mk(0, 1, 4'b0100, 4'b1010, VB, 4'b0100, "b_swap"));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b1010, VB, 4'b0000, "b_idle"));
    // C: unlimited burst never yields while the owner holds req
    vecs.push_back(mk(1, 2, 4'b0011, 4'b0011, VA, 4'b0001, "c_hold"));
    for (int i = 0; i < 19; i++)
      vecs.push_back(mk(0, 2, 4'b0011, 4'b0011, VA, 4'b0001, "c_hold"));
    vecs.push_back(mk(0, 2, 4'b0010, 4'b0011, VA, 4'b0010, "c_release0"));

    foreach (vecs[k]) apply(vecs[k]);

    // Asynchronous reset in the middle of a write burst
    apply(mk(1, 0, 4'b0001, 4'b0001, VA, 4'b0001, "m_own"));
    #2;
    reset = 1'b1;
    #1;
    check_zero(0, "m_async");
    a_req = 2'b10;
    a_we  = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero(0, "m_released");
    apply_now(mk(0, 0, 4'b0010, 4'b0011, VA, 4'b0010, "m_first"));

    cmp("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_bus_arbiter.md
Name: neuron_bus_arbiter

Overview:
- Parametrised, clocked successor to the two-way neuron memory bus mux.
- Arbitrates NUM_MASTERS requesters for one neuron memory port.
- Each requester drives read address, write address, write data and write enable. The arbiter grants exactly one owner and drives the registered shared bus from that owner.
- Supports round-robin or fixed-priority arbitration, burst ownership with a fairness cap, and an external-priority override on channel 0.

Parameters:
NUM_MASTERS, 2, number of requesting channels (>=2); channel 0 is the external/host channel
ADDR_WIDTH, 8, read/write address width
DATA_WIDTH, 8, write data width
MAX_BURST, 4, max consecutive owned cycles before forced handover when others wait; 0 = unlimited
EXT_PRIORITY, 1, 1 = channel 0 wins any arbitration in which it requests; 0 = pure round-robin

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_MASTERS  per-channel bus request, level held for the duration of ownership
read_address_in  input  NUM_MASTERS*ADDR_WIDTH  packed per-channel read address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
write_address_in  input  NUM_MASTERS*ADDR_WIDTH  packed per-channel write address
write_data_in  input  NUM_MASTERS*DATA_WIDTH  packed per-channel write data
write_enable_in  input  NUM_MASTERS  per-channel write enable
grant  output  NUM_MASTERS  one-hot owner (all zero when idle), registered
bus_busy  output  1  high while any channel owns the bus, registered
neuron_read_address  output  ADDR_WIDTH  registered selected read address
neuron_write_address  output  ADDR_WIDTH  registered selected write address
neuron_write_data  output  DATA_WIDTH  registered selected write data
neuron_write_enable  output  1  registered selected write enable, gated by owner's req

Behaviour:
- Reset (async, immediate):
  - grant=0, bus_busy=0, all neuron_* outputs=0.
  - Round-robin pointer last_owner=NUM_MASTERS-1, so index 0 is searched first.
  - Burst counter=0; state=IDLE.
  - Reset asserted mid-burst drops ownership instantly; no write may be issued in the cycle after reset is released unless a new grant is made.
- Arbitration function, combinational, over the candidate set C:
  - If EXT_PRIORITY=1 and channel 0 is in C, pick 0.
  - Otherwise pick the first requester in C scanning last_owner+1 upward, wrapping modulo NUM_MASTERS.
- States:
  - IDLE: if req!=0, arbitrate over all req bits and go to OWNED(winner) at the next edge, burst counter=1. Otherwise stay in IDLE.
  - OWNED(o), handover: if req[o]=0, arbitrate over the remaining req bits. If any exist, switch directly to the new owner with no idle cycle, counter=1; otherwise go to IDLE.
  - OWNED(o), forced handover: if req[o]=1, MAX_BURST!=0, counter==MAX_BURST and another channel requests, arbitrate excluding o and switch, counter=1. EXT_PRIORITY does not exempt channel 0 from this cap.
  - OWNED(o), otherwise: stay in OWNED(o); counter increments, saturating at MAX_BURST.
  - On every ownership change, last_owner is updated to the new owner.
- Datapath, one-cycle latency:
  - At each edge, grant, bus_busy and neuron_* load from the next owner, so the bus always matches grant.
  - neuron_* load that owner's inputs as sampled at that edge.
  - neuron_write_enable = write_enable_in[next] & req[next].
  - When the next state is IDLE, all neuron_* load 0, so neuron_write_enable=0.
- Invariants:
  - grant is always one-hot or zero.
  - A channel without req never receives a grant.
  - No two consecutive cycles show write enable from a channel whose req was low at sampling.
- Simultaneous events:
  - If the owner drops req while another channel raises req in the same cycle, the newcomer is granted at the next edge.
  - All channels requesting with EXT_PRIORITY=0 rotate strictly in index order.

Test Plan:
- NUM_MASTERS=2, EXT_PRIORITY=1; req=2'b11, ch0 addresses/data=8'hBE with we=1, ch1=8'hEF with we=0 -> after 1 edge: grant=01, all neuron_* = 8'hBE, write_enable=1. After MAX_BURST=4 owned cycles: grant=10, bus=8'hEF, write_enable=0.
- req=2'b10 only -> after 1 edge: grant=10, bus_busy=1, bus=8'hEF. Drop req -> next edge: grant=00, bus_busy=0, all outputs 0.
- NUM_MASTERS=4, EXT_PRIORITY=0, MAX_BURST=1, req=4'b1111 -> grant sequence 0001, 0010, 0100, 1000, 0001 on successive edges.
- Owner ch1 drops req in the same cycle ch2 raises req (NUM_MASTERS=4) -> next edge: grant=0100 with no IDLE gap, bus shows ch2 values.
- MAX_BURST=0, ch0 holds req for 20 cycles while ch1 requests -> grant stays 01 throughout. Release ch0 -> next edge: grant=10.
- Assert reset mid-burst while grant=01 and write_enable=1 -> outputs zero immediately, without waiting for a clock edge. Release reset with req=2'b10 -> first grant is 10.
